// File: rtl/control_fsm.sv
// control_fsm
// Multicycle control unit for the RISC-V `processing` datapath. It is pure
// control: it reads the IR and the ALU flags and drives the datapath strobes.
// Features: ready/valid memory handshakes with wait states, conditional
// branches (beq/bne/blt/bge), an illegal-opcode trap and a retired-instruction
// counter.
//
// Ports
//   clk, reset                 rising-edge clock, asynchronous active-high reset
//   instruction[31:0]          IR contents (opcode, funct3, funct7[5] are decoded)
//   ALUZero, ALULess           ALU flags (result == 0, signed A < B)
//   IMemReady, DMemReady       memory handshakes (ignored when MEM_HANDSHAKE = 0)
//   PCWrite, PCSource          PC load strobe and source (0 ALU, 1 ALUOut)
//   ALUSrcA, ALUSrcB, ALUOp    ALU operand and operation selects
//   LoadAOut, LoadRegA/B       ALUOut and operand register loads
//   RegWrite, MemToReg         register-file write and write-back source
//   IMemRead, IRWrite          instruction fetch request and IR load
//   DMemReq, DMemOp, LoadMDR   data memory request, direction and MDR load
//   Illegal                    sticky flag: undecodable opcode seen
//   InstrRet                   retired-instruction count (wraps)
//   StateOut                   current state encoding
module control_fsm #(
  parameter int ALUOP_W       = 3,
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit TRAP_HALT     = 1'b1,
  parameter int CNT_W         = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        instruction,
  input  logic               ALUZero,
  input  logic               ALULess,
  input  logic               IMemReady,
  input  logic               DMemReady,
  output logic               PCWrite,
  output logic               PCSource,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               LoadAOut,
  output logic               LoadRegA,
  output logic               LoadRegB,
  output logic               RegWrite,
  output logic               MemToReg,
  output logic               IMemRead,
  output logic               IRWrite,
  output logic               DMemReq,
  output logic               DMemOp,
  output logic               LoadMDR,
  output logic               Illegal,
  output logic [CNT_W-1:0]   InstrRet,
  output logic [3:0]         StateOut
);

  localparam logic [3:0] START        = 4'd0;
  localparam logic [3:0] INSTR_FETCH  = 4'd1;
  localparam logic [3:0] INSTR_DECODE = 4'd2;
  localparam logic [3:0] MEM_ADDR     = 4'd3;
  localparam logic [3:0] EXEC_R       = 4'd4;
  localparam logic [3:0] EXEC_I       = 4'd5;
  localparam logic [3:0] EXEC_U       = 4'd6;
  localparam logic [3:0] BRANCH       = 4'd7;
  localparam logic [3:0] MEM_LD       = 4'd8;
  localparam logic [3:0] MEM_SD       = 4'd9;
  localparam logic [3:0] WB_MEM       = 4'd10;
  localparam logic [3:0] WB_ALU       = 4'd11;
  localparam logic [3:0] TRAP         = 4'd12;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // Operation codes of the operations package used by the datapath ALU.
  localparam logic [ALUOP_W-1:0] ALU_SUM  = ALUOP_W'(3'd0);
  localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(3'd1);
  localparam logic [ALUOP_W-1:0] ALU_LOAD = ALUOP_W'(3'd7);

  // Dispatch target after decode; anything unknown traps.
  function automatic logic [3:0] decodeOpcode(input logic [6:0] op);
    logic [3:0] nxt;
    case (op)
      OPC_LOAD:   nxt = MEM_ADDR;
      OPC_STORE:  nxt = MEM_ADDR;
      OPC_OPIMM:  nxt = EXEC_I;
      OPC_OP:     nxt = EXEC_R;
      OPC_LUI:    nxt = EXEC_U;
      OPC_BRANCH: nxt = BRANCH;
      default:    nxt = TRAP;
    endcase
    return nxt;
  endfunction

  // Branch condition from funct3; unsupported funct3 values never branch.
  function automatic logic branchTaken(input logic [2:0] f3, input logic zero,
                                       input logic less);
    logic tk;
    case (f3)
      3'b000:  tk = zero;
      3'b001:  tk = ~zero;
      3'b100:  tk = less;
      3'b101:  tk = ~less;
      default: tk = 1'b0;
    endcase
    return tk;
  endfunction

  // {funct7[5], funct3} is zero-extended or truncated to the ALUOp width.
  function automatic logic [ALUOP_W-1:0] fitAluOp(input logic [3:0] f);
    return ALUOP_W'(f);
  endfunction

  logic [3:0]       state_r;
  logic [3:0]       nextState_s;
  logic [CNT_W-1:0] instrRet_r;
  logic             illegal_r;
  logic             iReady_s;
  logic             dReady_s;
  logic             retire_s;
  logic             enterTrap_s;
  logic [6:0]       opcode_s;
  logic [2:0]       funct3_s;
  logic             funct7b5_s;
  logic             unusedIrBits_s;

  assign opcode_s   = instruction[6:0];
  assign funct3_s   = instruction[14:12];
  assign funct7b5_s = instruction[30];
  assign unusedIrBits_s = ^{instruction[31], instruction[29:15], instruction[11:7]};

  // Without handshakes the memories are assumed to answer in one cycle.
  assign iReady_s = MEM_HANDSHAKE ? IMemReady : 1'b1;
  assign dReady_s = MEM_HANDSHAKE ? DMemReady : 1'b1;

  // Final cycle of every instruction: the counter steps on its exiting edge.
  assign retire_s = (state_r == WB_MEM) || (state_r == WB_ALU) ||
                    (state_r == BRANCH) || ((state_r == MEM_SD) && dReady_s);

  assign enterTrap_s = (nextState_s == TRAP) && (state_r != TRAP);

  // Next-state selection.
  always_comb begin
    nextState_s = START;
    case (state_r)
      START:        nextState_s = INSTR_FETCH;
      INSTR_FETCH: begin
        if (iReady_s) nextState_s = INSTR_DECODE;
        else          nextState_s = INSTR_FETCH;
      end
      INSTR_DECODE: nextState_s = decodeOpcode(opcode_s);
      MEM_ADDR: begin
        if (opcode_s == OPC_LOAD) nextState_s = MEM_LD;
        else                      nextState_s = MEM_SD;
      end
      MEM_LD: begin
        if (dReady_s) nextState_s = WB_MEM;
        else          nextState_s = MEM_LD;
      end
      MEM_SD: begin
        if (dReady_s) nextState_s = INSTR_FETCH;
        else          nextState_s = MEM_SD;
      end
      EXEC_R, EXEC_I, EXEC_U:  nextState_s = WB_ALU;
      WB_MEM, WB_ALU, BRANCH:  nextState_s = INSTR_FETCH;
      TRAP: begin
        if (TRAP_HALT) nextState_s = TRAP;
        else           nextState_s = INSTR_FETCH;
      end
      default:      nextState_s = START;
    endcase
  end

  // Datapath strobes, decoded from the current state (and handshakes/flags).
  always_comb begin
    PCWrite  = 1'b0;
    PCSource = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'd0;
    ALUOp    = ALU_SUM;
    LoadAOut = 1'b0;
    LoadRegA = 1'b0;
    LoadRegB = 1'b0;
    RegWrite = 1'b0;
    MemToReg = 1'b0;
    IMemRead = 1'b0;
    IRWrite  = 1'b0;
    DMemReq  = 1'b0;
    DMemOp   = 1'b0;
    LoadMDR  = 1'b0;
    case (state_r)
      INSTR_FETCH: begin
        IMemRead = 1'b1;
        ALUSrcB  = 2'd1;
        // PC and IR only move on the cycle the fetch data is valid.
        if (iReady_s) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
        end else begin
          IRWrite = 1'b0;
          PCWrite = 1'b0;
        end
      end
      INSTR_DECODE: begin
        // Speculative branch target PC + (imm << 1) parked in ALUOut.
        LoadRegA = 1'b1;
        LoadRegB = 1'b1;
        LoadAOut = 1'b1;
        ALUSrcB  = 2'd3;
      end
      MEM_ADDR: begin
        LoadAOut = 1'b1;
        ALUSrcA  = 1'b1;
        ALUSrcB  = 2'd2;
      end
      MEM_LD: begin
        DMemReq = 1'b1;
        DMemOp  = 1'b0;
        if (dReady_s) LoadMDR = 1'b1;
        else          LoadMDR = 1'b0;
      end
      MEM_SD: begin
        DMemReq = 1'b1;
        DMemOp  = 1'b1;
      end
      WB_MEM: begin
        RegWrite = 1'b1;
        MemToReg = 1'b1;
      end
      EXEC_R: begin
        ALUSrcA  = 1'b1;
        ALUSrcB  = 2'd0;
        LoadAOut = 1'b1;
        ALUOp    = fitAluOp({funct7b5_s, funct3_s});
      end
      EXEC_I: begin
        // Immediate forms carry imm bits in funct7; only srai uses bit 30.
        ALUSrcA  = 1'b1;
        ALUSrcB  = 2'd2;
        LoadAOut = 1'b1;
        ALUOp    = fitAluOp({funct7b5_s & (funct3_s == 3'b101), funct3_s});
      end
      EXEC_U: begin
        ALUSrcB  = 2'd2;
        LoadAOut = 1'b1;
        ALUOp    = ALU_LOAD;
      end
      WB_ALU: begin
        RegWrite = 1'b1;
        MemToReg = 1'b0;
      end
      BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUSrcB  = 2'd0;
        ALUOp    = ALU_SUB;
        PCSource = 1'b1;
        PCWrite  = branchTaken(funct3_s, ALUZero, ALULess);
      end
      default: begin
        PCWrite = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= START;
    else       state_r <= nextState_s;
  end

  // Retired-instruction counter, wrapping modulo 2^CNT_W.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         instrRet_r <= '0;
    else if (retire_s) instrRet_r <= instrRet_r + CNT_W'(1'b1);
    else               instrRet_r <= instrRet_r;
  end

  // Sticky illegal-opcode flag, set on the edge that enters TRAP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            illegal_r <= 1'b0;
    else if (enterTrap_s) illegal_r <= 1'b1;
    else                  illegal_r <= illegal_r;
  end

  assign Illegal  = illegal_r;
  assign InstrRet = instrRet_r;
  assign StateOut = state_r;

endmodule

// File: tb/tb_control_fsm.sv
module tb_control_fsm;

  localparam int AW = 4;

  localparam logic [3:0] S_START  = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_MADDR  = 4'd3;
  localparam logic [3:0] S_EXR    = 4'd4;
  localparam logic [3:0] S_EXI    = 4'd5;
  localparam logic [3:0] S_EXU    = 4'd6;
  localparam logic [3:0] S_BR     = 4'd7;
  localparam logic [3:0] S_LD     = 4'd8;
  localparam logic [3:0] S_SD     = 4'd9;
  localparam logic [3:0] S_WBM    = 4'd10;
  localparam logic [3:0] S_WBA    = 4'd11;
  localparam logic [3:0] S_TRAP   = 4'd12;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef struct {
    logic [3:0]  st;
    logic [31:0] ins;
    logic        ir;
    logic        dr;
    logic        z;
    logic        l;
    logic [7:0]  ret;
    logic        ill;
  } rec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main DUT: handshakes on, halting trap, 4-bit ALUOp, 8-bit counter
  logic          reset;
  logic [31:0]   instruction;
  logic          ALUZero, ALULess, IMemReady, DMemReady;
  logic          PCWrite, PCSource, ALUSrcA, LoadAOut, LoadRegA, LoadRegB;
  logic          RegWrite, MemToReg, IMemRead, IRWrite, DMemReq, DMemOp, LoadMDR, Illegal;
  logic [1:0]    ALUSrcB;
  logic [AW-1:0] ALUOp;
  logic [7:0]    InstrRet;
  logic [3:0]    StateOut;
  logic [14:0]   dutStr;

  control_fsm #(.ALUOP_W(AW), .MEM_HANDSHAKE(1'b1), .TRAP_HALT(1'b1), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .instruction(instruction), .ALUZero(ALUZero),
    .ALULess(ALULess), .IMemReady(IMemReady), .DMemReady(DMemReady),
    .PCWrite(PCWrite), .PCSource(PCSource), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .LoadAOut(LoadAOut), .LoadRegA(LoadRegA), .LoadRegB(LoadRegB),
    .RegWrite(RegWrite), .MemToReg(MemToReg), .IMemRead(IMemRead), .IRWrite(IRWrite),
    .DMemReq(DMemReq), .DMemOp(DMemOp), .LoadMDR(LoadMDR), .Illegal(Illegal),
    .InstrRet(InstrRet), .StateOut(StateOut));

  assign dutStr = {PCWrite, PCSource, ALUSrcA, ALUSrcB, LoadAOut, LoadRegA, LoadRegB,
                   RegWrite, MemToReg, IMemRead, IRWrite, DMemReq, DMemOp, LoadMDR};

  // second DUT: fixed latency, non-halting trap
  logic        reset2;
  logic [31:0] ins2;
  logic        z2, l2, ir2, dr2;
  logic        pcw2, pcs2, asa2, lao2, lra2, lrb2, rw2, m2r2, imr2, irw2, dmq2, dmo2, lmdr2, ill2;
  logic [1:0]  asb2;
  logic [2:0]  aop2;
  logic [7:0]  ret2;
  logic [3:0]  st2;

  control_fsm #(.ALUOP_W(3), .MEM_HANDSHAKE(1'b0), .TRAP_HALT(1'b0), .CNT_W(8)) dut2 (
    .clk(clk), .reset(reset2), .instruction(ins2), .ALUZero(z2), .ALULess(l2),
    .IMemReady(ir2), .DMemReady(dr2), .PCWrite(pcw2), .PCSource(pcs2), .ALUSrcA(asa2),
    .ALUSrcB(asb2), .ALUOp(aop2), .LoadAOut(lao2), .LoadRegA(lra2), .LoadRegB(lrb2),
    .RegWrite(rw2), .MemToReg(m2r2), .IMemRead(imr2), .IRWrite(irw2), .DMemReq(dmq2),
    .DMemOp(dmo2), .LoadMDR(lmdr2), .Illegal(ill2), .InstrRet(ret2), .StateOut(st2));

  int   nVec = 0;
  int   nMis = 0;
  rec_t tr[$];
  rec_t cur;
  logic checkEn = 1'b0;
  logic [7:0] mRet;
  logic       mIll;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec = nVec + 1;
    if (act !== exp) begin
      nMis = nMis + 1;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(1, 0));
  endfunction

  function automatic logic isLegal(input logic [6:0] op);
    return (op == OPC_LOAD) || (op == OPC_STORE) || (op == OPC_OPIMM) ||
           (op == OPC_OP) || (op == OPC_LUI) || (op == OPC_BRANCH);
  endfunction

  // random instruction of a given class (6 = illegal opcode)
  function automatic logic [31:0] randInstr(input int kind);
    logic [31:0] w;
    w = $urandom();
    case (kind)
      0: w[6:0] = OPC_LOAD;
      1: w[6:0] = OPC_STORE;
      2: w[6:0] = OPC_OPIMM;
      3: w[6:0] = OPC_OP;
      4: w[6:0] = OPC_LUI;
      5: w[6:0] = OPC_BRANCH;
      default: begin
        w[6:0] = 7'h7F;
        for (int k = 0; k < 20; k++) begin
          w[6:0] = 7'($urandom());
          if (!isLegal(w[6:0])) break;
        end
        if (isLegal(w[6:0])) w[6:0] = 7'h7F;
      end
    endcase
    return w;
  endfunction

  // one cycle of expected behaviour; expected counter is the value before it
  task automatic push(input logic [3:0] st, input logic [31:0] ins, input logic ir,
                      input logic dr, input logic z, input logic l, input logic retires);
    rec_t r;
    if (st == S_TRAP) mIll = 1'b1;
    r.st = st; r.ins = ins; r.ir = ir; r.dr = dr; r.z = z; r.l = l;
    r.ret = mRet; r.ill = mIll;
    tr.push_back(r);
    if (retires) mRet = mRet + 8'd1;
  endtask

  // expand one instruction into its cycle sequence
  task automatic addInstr(input logic [31:0] ins, input int fw, input int dw);
    for (int i = 0; i < fw; i++) push(S_FETCH, $urandom(), 1'b0, rb(), rb(), rb(), 1'b0);
    push(S_FETCH, $urandom(), 1'b1, rb(), rb(), rb(), 1'b0);
    push(S_DECODE, ins, rb(), rb(), rb(), rb(), 1'b0);
    case (ins[6:0])
      OPC_LOAD: begin
        push(S_MADDR, ins, rb(), rb(), rb(), rb(), 1'b0);
        for (int i = 0; i < dw; i++) push(S_LD, ins, rb(), 1'b0, rb(), rb(), 1'b0);
        push(S_LD, ins, rb(), 1'b1, rb(), rb(), 1'b0);
        push(S_WBM, ins, rb(), rb(), rb(), rb(), 1'b1);
      end
      OPC_STORE: begin
        push(S_MADDR, ins, rb(), rb(), rb(), rb(), 1'b0);
        for (int i = 0; i < dw; i++) push(S_SD, ins, rb(), 1'b0, rb(), rb(), 1'b0);
        push(S_SD, ins, rb(), 1'b1, rb(), rb(), 1'b1);
      end
      OPC_OPIMM: begin
        push(S_EXI, ins, rb(), rb(), rb(), rb(), 1'b0);
        push(S_WBA, ins, rb(), rb(), rb(), rb(), 1'b1);
      end
      OPC_OP: begin
        push(S_EXR, ins, rb(), rb(), rb(), rb(), 1'b0);
        push(S_WBA, ins, rb(), rb(), rb(), rb(), 1'b1);
      end
      OPC_LUI: begin
        push(S_EXU, ins, rb(), rb(), rb(), rb(), 1'b0);
        push(S_WBA, ins, rb(), rb(), rb(), rb(), 1'b1);
      end
      OPC_BRANCH: push(S_BR, ins, rb(), rb(), rb(), rb(), 1'b1);
      default: for (int i = 0; i < 10; i++) push(S_TRAP, ins, rb(), rb(), rb(), rb(), 1'b0);
    endcase
  endtask

  // {PCWrite,PCSource,ALUSrcA,ALUSrcB,LoadAOut,LoadRegA,LoadRegB,RegWrite,MemToReg,
  //  IMemRead,IRWrite,DMemReq,DMemOp,LoadMDR}
  function automatic logic [14:0] expStrobes(input rec_t r);
    logic [2:0] f3;
    logic tk;
    f3 = r.ins[14:12];
    tk = (f3 == 3'b000) ? r.z : (f3 == 3'b001) ? !r.z :
         (f3 == 3'b100) ? r.l : (f3 == 3'b101) ? !r.l : 1'b0;
    case (r.st)
      S_FETCH:  return {1'b0, 1'b0, 1'b0, 2'd1, 3'b000, 2'b00, 1'b1, r.ir, 3'b000} | {r.ir, 14'd0};
      S_DECODE: return {1'b0, 1'b0, 1'b0, 2'd3, 3'b111, 2'b00, 2'b00, 3'b000};
      S_MADDR:  return {1'b0, 1'b0, 1'b1, 2'd2, 3'b100, 2'b00, 2'b00, 3'b000};
      S_LD:     return {1'b0, 1'b0, 1'b0, 2'd0, 3'b000, 2'b00, 2'b00, 1'b1, 1'b0, r.dr};
      S_SD:     return {1'b0, 1'b0, 1'b0, 2'd0, 3'b000, 2'b00, 2'b00, 3'b110};
      S_WBM:    return {1'b0, 1'b0, 1'b0, 2'd0, 3'b000, 2'b11, 2'b00, 3'b000};
      S_EXR:    return {1'b0, 1'b0, 1'b1, 2'd0, 3'b100, 2'b00, 2'b00, 3'b000};
      S_EXI:    return {1'b0, 1'b0, 1'b1, 2'd2, 3'b100, 2'b00, 2'b00, 3'b000};
      S_EXU:    return {1'b0, 1'b0, 1'b0, 2'd2, 3'b100, 2'b00, 2'b00, 3'b000};
      S_WBA:    return {1'b0, 1'b0, 1'b0, 2'd0, 3'b000, 2'b10, 2'b00, 3'b000};
      S_BR:     return {tk, 1'b1, 1'b1, 2'd0, 3'b000, 2'b00, 2'b00, 3'b000};
      default:  return 15'd0;
    endcase
  endfunction

  // ALU codes: SUM=0, SUB=1, LOAD=7, R/I ops use {funct7[5], funct3}
  function automatic logic [3:0] expAlu(input rec_t r);
    case (r.st)
      S_EXR:   return {r.ins[30], r.ins[14:12]};
      S_EXI:   return (r.ins[14:12] == 3'b101) ? {r.ins[30], 3'b101} : {1'b0, r.ins[14:12]};
      S_EXU:   return 4'd7;
      S_BR:    return 4'd1;
      default: return 4'd0;
    endcase
  endfunction

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (checkEn) begin
      check("state", 32'(StateOut), 32'(cur.st));
      check("strobes", 32'(dutStr), 32'(expStrobes(cur)));
      check("aluop", 32'(ALUOp), 32'(expAlu(cur)));
      check("instret", 32'(InstrRet), 32'(cur.ret));
      check("illegal", 32'(Illegal), 32'(cur.ill));
    end
  end

  task automatic runTrace(input int n);
    rec_t r;
    for (int i = 0; i < n; i++) begin
      r = tr.pop_front();
      instruction = r.ins; IMemReady = r.ir; DMemReady = r.dr; ALUZero = r.z; ALULess = r.l;
      cur = r;
      checkEn = 1'b1;
      @(posedge clk); #1;
    end
    checkEn = 1'b0;
  endtask

  // ends 1 time unit after a rising edge, with the DUT in START
  task automatic doReset();
    checkEn = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check("rst_state", 32'(StateOut), 32'd0);
    check("rst_dmemreq", 32'(DMemReq), 32'd0);
    check("rst_instret", 32'(InstrRet), 32'd0);
    check("rst_illegal", 32'(Illegal), 32'd0);
    check("rst_strobes", 32'(dutStr), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    mRet = 8'd0; mIll = 1'b0;
    tr.delete();
  endtask

  logic [3:0] addiStates [5];
  logic       addiRw     [5];
  logic [3:0] dut2States [9];
  int n;

  initial begin
    reset = 1'b1; instruction = 32'd0; ALUZero = 1'b0; ALULess = 1'b0;
    IMemReady = 1'b0; DMemReady = 1'b0;
    reset2 = 1'b1; ins2 = 32'd0; z2 = 1'b0; l2 = 1'b0; ir2 = 1'b0; dr2 = 1'b0;
    mRet = 8'd0; mIll = 1'b0;
    addiStates = '{4'd1, 4'd2, 4'd5, 4'd11, 4'd1};
    addiRw     = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    dut2States = '{4'd1, 4'd2, 4'd12, 4'd1, 4'd2, 4'd3, 4'd8, 4'd10, 4'd1};
    #3;
    check("init_state", 32'(StateOut), 32'd0);
    check("init_strobes", 32'(dutStr), 32'd0);

    // zero-wait ADDI, literal expectations
    doReset();
    instruction = 32'h00500093; IMemReady = 1'b1; DMemReady = 1'b1;
    check("addi_ret0", 32'(InstrRet), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("addi_state", 32'(StateOut), 32'(addiStates[i]));
      check("addi_regwrite", 32'(RegWrite), 32'(addiRw[i]));
    end
    check("addi_ret1", 32'(InstrRet), 32'd1);

    // load with three data wait states: 8 cycles after START
    doReset();
    push(S_START, $urandom(), rb(), rb(), rb(), rb(), 1'b0);
    addInstr(32'h00002083, 0, 3);
    check("ld_len", 32'(tr.size()), 32'd9);
    runTrace(tr.size());

    // random mixes with random wait states
    for (int ep = 0; ep < 4; ep++) begin
      doReset();
      push(S_START, $urandom(), rb(), rb(), rb(), rb(), 1'b0);
      for (int k = 0; k < 25; k++)
        addInstr(randInstr(int'($urandom_range(5, 0))), int'($urandom_range(3, 0)),
                 int'($urandom_range(3, 0)));
      runTrace(tr.size());
    end

    // long zero-wait run that wraps the 8-bit counter: 270 mod 256 = 14
    doReset();
    push(S_START, $urandom(), rb(), rb(), rb(), rb(), 1'b0);
    for (int k = 0; k < 270; k++) addInstr(randInstr(int'($urandom_range(5, 0))), 0, 0);
    runTrace(tr.size());
    check("wrap_instret", 32'(InstrRet), 32'd14);

    // halting trap after one retired instruction
    doReset();
    push(S_START, $urandom(), rb(), rb(), rb(), rb(), 1'b0);
    addInstr(randInstr(2), 1, 0);
    addInstr(32'h0000007F, 0, 0);
    runTrace(tr.size());
    check("trap_state", 32'(StateOut), 32'd12);
    check("trap_illegal", 32'(Illegal), 32'd1);
    check("trap_instret", 32'(InstrRet), 32'd1);

    // random illegal opcode
    doReset();
    push(S_START, $urandom(), rb(), rb(), rb(), rb(), 1'b0);
    addInstr(randInstr(6), 2, 0);
    runTrace(tr.size());

    // reset during a stalled store
    doReset();
    push(S_START, $urandom(), rb(), rb(), rb(), rb(), 1'b0);
    addInstr(32'h00500093, 0, 0);
    addInstr(randInstr(1), 0, 5);
    n = tr.size();
    runTrace(n - 4);
    DMemReady = 1'b0;
    #2;
    check("sd_state", 32'(StateOut), 32'd9);
    check("sd_dmemreq", 32'(DMemReq), 32'd1);
    check("sd_instret", 32'(InstrRet), 32'd1);
    reset = 1'b1;
    #1;
    check("abort_dmemreq", 32'(DMemReq), 32'd0);
    check("abort_state", 32'(StateOut), 32'd0);
    check("abort_instret", 32'(InstrRet), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    check("after_rst_state", 32'(StateOut), 32'd0);
    @(posedge clk); #1;
    check("after_rst_fetch", 32'(StateOut), 32'd1);
    tr.delete();

    // fixed-latency, non-halting instance: trap then a one-cycle load
    @(posedge clk); #1;
    ins2 = 32'h0000007F;
    reset2 = 1'b0;
    check("d2_start", 32'(st2), 32'd0);
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      check("d2_state", 32'(st2), 32'(dut2States[i]));
      if (i == 0) check("d2_irwrite", 32'(irw2), 32'd1);
      if (i == 2) check("d2_illegal", 32'(ill2), 32'd1);
      if (i == 3) begin
        check("d2_illegal_sticky", 32'(ill2), 32'd1);
        check("d2_trap_noret", 32'(ret2), 32'd0);
        ins2 = 32'h00002083;
      end
      if (i == 6) check("d2_loadmdr", 32'(lmdr2), 32'd1);
    end
    check("d2_instret", 32'(ret2), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
